// File: rtl/dco_tune_ctrl.sv
// DCO coarse/medium/fine bank-word calibration: PVT -> ACQ -> TRK stepping on a signed error.
// Optional macro DCO_TUNE_CTRL_RECENTER_EN recentres c_s_word into c_m_word in TRK.
`timescale 1ns/1ps
module dco_tune_ctrl #(
    parameter logic [4:0]  L_INIT     = 5'd16,
    parameter logic [7:0]  M_INIT     = 8'd128,
    parameter logic [7:0]  S_INIT     = 8'd128,
    parameter logic [15:0] THR_L      = 16'd2048,
    parameter logic [15:0] THR_M      = 16'd256,
    parameter logic [15:0] THR_S      = 16'd16,
    parameter logic [7:0]  LOCK_CNT   = 8'd8,
    parameter logic [7:0]  SETTLE_CYC = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic        err_vld,
    input  logic [15:0] err,
    output logic [4:0]  c_l_word,
    output logic [7:0]  c_m_word,
    output logic [7:0]  c_s_word,
    output logic [1:0]  mode,
    output logic        lock
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PVT  = 2'd1,
        ST_ACQ  = 2'd2,
        ST_TRK  = 2'd3
    } state_t;

    state_t      state_r, state_nx_s;
    logic [4:0]  c_l_r, c_l_nx_s;
    logic [7:0]  c_m_r, c_m_nx_s;
    logic [7:0]  c_s_r, c_s_nx_s;
    logic        lock_r, lock_nx_s;
    logic [7:0]  settle_r, settle_nx_s;
    logic [7:0]  band_r, band_nx_s;

    logic [15:0]        thr_sel_s;
    logic signed [16:0] err_ext_s;
    logic signed [16:0] thr_pos_s;
    logic signed [16:0] thr_neg_s;
    logic               step_dn_s;
    logic               step_up_s;
    logic               in_band_s;
    logic               accept_s;
    logic               word_chg_s;
    logic [8:0]         band_inc_s;
    logic               reach_s;

    // Magnitude limit of the mode currently being calibrated
    always_comb begin
        thr_sel_s = THR_L;
        case (state_r)
            ST_PVT:  thr_sel_s = THR_L;
            ST_ACQ:  thr_sel_s = THR_M;
            ST_TRK:  thr_sel_s = THR_S;
            default: thr_sel_s = THR_L;
        endcase
    end

    // 17-bit compare so that -32768 lands out of band without overflow
    assign err_ext_s  = $signed({err[15], err});
    assign thr_pos_s  = $signed({1'b0, thr_sel_s});
    assign thr_neg_s  = -thr_pos_s;
    assign step_dn_s  = (err_ext_s > thr_pos_s);
    assign step_up_s  = (err_ext_s < thr_neg_s);
    assign in_band_s  = !step_dn_s && !step_up_s;
    assign accept_s   = en && err_vld && (settle_r == 8'd0) && (state_r != ST_IDLE);
    assign band_inc_s = {1'b0, band_r} + 9'd1;
    assign reach_s    = (band_inc_s >= {1'b0, LOCK_CNT});

    // Next-state, word stepping, settle and in-band bookkeeping
    always_comb begin
        state_nx_s  = state_r;
        c_l_nx_s    = c_l_r;
        c_m_nx_s    = c_m_r;
        c_s_nx_s    = c_s_r;
        lock_nx_s   = lock_r;
        band_nx_s   = band_r;
        word_chg_s  = 1'b0;
        if (settle_r != 8'd0) begin
            settle_nx_s = settle_r - 8'd1;
        end else begin
            settle_nx_s = 8'd0;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_PVT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PVT: begin
                if (accept_s && step_dn_s && (c_l_r != 5'd0)) begin
                    c_l_nx_s   = c_l_r - 5'd1;
                    word_chg_s = 1'b1;
                end else if (accept_s && step_up_s && (c_l_r != 5'd31)) begin
                    c_l_nx_s   = c_l_r + 5'd1;
                    word_chg_s = 1'b1;
                end else begin
                    c_l_nx_s = c_l_r;
                end
            end
            ST_ACQ: begin
                if (accept_s && step_dn_s && (c_m_r != 8'd0)) begin
                    c_m_nx_s   = c_m_r - 8'd1;
                    word_chg_s = 1'b1;
                end else if (accept_s && step_up_s && (c_m_r != 8'd255)) begin
                    c_m_nx_s   = c_m_r + 8'd1;
                    word_chg_s = 1'b1;
                end else begin
                    c_m_nx_s = c_m_r;
                end
            end
            ST_TRK: begin
                if (accept_s && step_dn_s) begin
                    if (c_s_r != 8'd0) begin
                        c_s_nx_s   = c_s_r - 8'd1;
                        word_chg_s = 1'b1;
                    end else begin
`ifdef DCO_TUNE_CTRL_RECENTER_EN
                        // Fine bank underflow: recentre and move the medium bank up
                        c_s_nx_s   = 8'd128;
                        c_m_nx_s   = (c_m_r != 8'd255) ? (c_m_r + 8'd1) : c_m_r;
                        word_chg_s = 1'b1;
`else
                        c_s_nx_s = c_s_r;
`endif
                    end
                end else if (accept_s && step_up_s) begin
                    if (c_s_r != 8'd255) begin
                        c_s_nx_s   = c_s_r + 8'd1;
                        word_chg_s = 1'b1;
                    end else begin
`ifdef DCO_TUNE_CTRL_RECENTER_EN
                        c_s_nx_s   = 8'd128;
                        c_m_nx_s   = (c_m_r != 8'd0) ? (c_m_r - 8'd1) : c_m_r;
                        word_chg_s = 1'b1;
`else
                        c_s_nx_s = c_s_r;
`endif
                    end
                end else begin
                    c_s_nx_s = c_s_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        if (word_chg_s) begin
            settle_nx_s = SETTLE_CYC;
        end else begin
            settle_nx_s = settle_nx_s;
        end

        // Consecutive in-band run; PVT/ACQ advance on reaching it, TRK saturates and locks
        if (accept_s && in_band_s) begin
            if (reach_s) begin
                if (state_r == ST_TRK) begin
                    band_nx_s = LOCK_CNT;
                    lock_nx_s = 1'b1;
                end else begin
                    band_nx_s   = 8'd0;
                    settle_nx_s = SETTLE_CYC;
                    state_nx_s  = (state_r == ST_PVT) ? ST_ACQ : ST_TRK;
                end
            end else begin
                band_nx_s = band_inc_s[7:0];
            end
        end else if (accept_s) begin
            band_nx_s = 8'd0;
            if (state_r == ST_TRK) begin
                lock_nx_s = 1'b0;
            end else begin
                lock_nx_s = lock_r;
            end
        end else begin
            band_nx_s = band_r;
        end
    end

    // State and output registers; reset wins over the clock enable
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            c_l_r    <= L_INIT;
            c_m_r    <= M_INIT;
            c_s_r    <= S_INIT;
            lock_r   <= 1'b0;
            settle_r <= 8'd0;
            band_r   <= 8'd0;
        end else if (en) begin
            state_r  <= state_nx_s;
            c_l_r    <= c_l_nx_s;
            c_m_r    <= c_m_nx_s;
            c_s_r    <= c_s_nx_s;
            lock_r   <= lock_nx_s;
            settle_r <= settle_nx_s;
            band_r   <= band_nx_s;
        end else begin
            state_r  <= state_r;
            c_l_r    <= c_l_r;
            c_m_r    <= c_m_r;
            c_s_r    <= c_s_r;
            lock_r   <= lock_r;
            settle_r <= settle_r;
            band_r   <= band_r;
        end
    end

    assign c_l_word = c_l_r;
    assign c_m_word = c_m_r;
    assign c_s_word = c_s_r;
    assign mode     = state_r;
    assign lock     = lock_r;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Directed self-checking bench for dco_tune_ctrl (default parameters).
// Expectations for the TRK fine-bank overflow follow DCO_TUNE_CTRL_RECENTER_EN.
`timescale 1ns/1ps
module tb_dco_tune_ctrl;

    logic               clk;
    logic               rst;
    logic               en;
    logic               start;
    logic               err_vld;
    logic signed [15:0] err;
    logic [4:0]         c_l_word;
    logic [7:0]         c_m_word;
    logic [7:0]         c_s_word;
    logic [1:0]         mode;
    logic               lock;

    int errors = 0;
    int checks = 0;

    dco_tune_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .err_vld  (err_vld),
        .err      (err),
        .c_l_word (c_l_word),
        .c_m_word (c_m_word),
        .c_s_word (c_s_word),
        .mode     (mode),
        .lock     (lock)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input logic signed [15:0] e);
        err_vld = 1'b1;
        err     = e;
        tick(1);
        err_vld = 1'b0;
        err     = 16'sd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        en      = 1'b0;
        start   = 1'b0;
        err_vld = 1'b0;
        err     = 16'sd0;

        // reset applies even with en=0
        tick(1);
        rst = 1'b0;
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_l", 32'(c_l_word), 32'd16);
        chk("rst_m", 32'(c_m_word), 32'd128);
        chk("rst_s", 32'(c_s_word), 32'd128);
        chk("rst_lock", 32'(lock), 32'd0);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_en0", 32'(mode), 32'd0);
        en = 1'b1;
        tick(1);
        chk("idle_no_start", 32'(mode), 32'd0);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("enter_pvt", 32'(mode), 32'd1);
        chk("enter_pvt_l", 32'(c_l_word), 32'd16);

        // PVT: +5000 every cycle, one step per 5 cycles down to 0
        err_vld = 1'b1;
        err     = 16'sd5000;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk("pvt_step", 32'(c_l_word), 32'(16 - k));
            tick(4);
            chk("pvt_settle_hold", 32'(c_l_word), 32'(16 - k));
        end
        tick(1);
        chk("pvt_sat", 32'(c_l_word), 32'd0);

        // no settle after saturated step: in-band run starts immediately
        err = 16'sd100;
        tick(7);
        chk("pvt_run7", 32'(mode), 32'd1);
        err = 16'sd3000;
        tick(1);
        chk("pvt_break", 32'(mode), 32'd1);
        chk("pvt_break_l", 32'(c_l_word), 32'd0);
        err = 16'sd100;
        tick(7);
        chk("pvt_restart", 32'(mode), 32'd1);
        tick(1);
        err_vld = 1'b0;
        chk("pvt_to_acq", 32'(mode), 32'd2);

        // ACQ: sample inside the transition settle is ignored
        sample(-16'sd1000);
        chk("acq_settle_ignore", 32'(c_m_word), 32'd128);
        tick(3);
        en      = 1'b0;
        err_vld = 1'b1;
        err     = -16'sd1000;
        tick(2);
        chk("en0_discard_m", 32'(c_m_word), 32'd128);
        chk("en0_discard_mode", 32'(mode), 32'd2);
        en      = 1'b1;
        err_vld = 1'b0;
        sample(-16'sd1000);
        chk("acq_step_up", 32'(c_m_word), 32'd129);
        tick(4);
        sample(16'sd50);
        sample(16'sd50);
        sample(16'sd50);

        // reset in ACQ aborts calibration
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_acq_mode", 32'(mode), 32'd0);
        chk("rst_acq_l", 32'(c_l_word), 32'd16);
        chk("rst_acq_m", 32'(c_m_word), 32'd128);
        chk("rst_acq_s", 32'(c_s_word), 32'd128);
        tick(1);
        chk("rst_needs_start", 32'(mode), 32'd0);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("restart_pvt", 32'(mode), 32'd1);
        err_vld = 1'b1;
        err     = 16'sd100;
        tick(8);
        err_vld = 1'b0;
        chk("pvt_to_acq2", 32'(mode), 32'd2);
        chk("pvt_to_acq2_l", 32'(c_l_word), 32'd16);
        tick(4);
        err_vld = 1'b1;
        err     = 16'sd50;
        tick(7);
        err_vld = 1'b0;
        chk("acq_run7", 32'(mode), 32'd2);
        en      = 1'b0;
        err_vld = 1'b1;
        tick(1);
        err_vld = 1'b0;
        en      = 1'b1;
        chk("acq_en0_hold", 32'(mode), 32'd2);
        sample(16'sd50);
        chk("acq_to_trk", 32'(mode), 32'd3);
        chk("acq_to_trk_m", 32'(c_m_word), 32'd128);

        // TRK: lock after 8 in-band samples, drop on out-of-band
        tick(4);
        err_vld = 1'b1;
        err     = 16'sd0;
        tick(7);
        chk("trk_lock_pre", 32'(lock), 32'd0);
        tick(1);
        err_vld = 1'b0;
        chk("trk_lock", 32'(lock), 32'd1);
        sample(-16'sd200);
        chk("trk_unlock", 32'(lock), 32'd0);
        chk("trk_step", 32'(c_s_word), 32'd129);
        chk("trk_step_m", 32'(c_m_word), 32'd128);
        tick(4);
        sample(16'sh8000);
        chk("trk_min_err", 32'(c_s_word), 32'd130);
        tick(4);
        sample(16'sd16);
        chk("trk_thr_edge", 32'(c_s_word), 32'd130);
        sample(16'sd17);
        chk("trk_thr_over", 32'(c_s_word), 32'd129);

        // climb the fine bank to its top
        err_vld = 1'b1;
        err     = -16'sd200;
        for (int i = 0; i < 2000 && c_s_word != 8'd255; i++) begin
            tick(1);
        end
        err_vld = 1'b0;
        chk("trk_climb", 32'(c_s_word), 32'd255);
        tick(5);
        sample(-16'sd200);
`ifdef DCO_TUNE_CTRL_RECENTER_EN
        chk("recenter_s", 32'(c_s_word), 32'd128);
        chk("recenter_m", 32'(c_m_word), 32'd127);
`else
        chk("sat_s", 32'(c_s_word), 32'd255);
        chk("sat_m", 32'(c_m_word), 32'd128);
`endif
        chk("trk_terminal", 32'(mode), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
